// File: rtl/alu_scan_ctrl.sv
// Sequencing controller for the 3-bit ALU display datapath: captures operands,
// lets them settle, then scans the four digits and alternates add/sub per frame block.
module alu_scan_ctrl #(
    parameter int DATA_W       = 3,
    parameter int REFRESH_DIV  = 50000,
    parameter int CYCLE_FRAMES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              load,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        op_code,
    output logic [1:0]        digit_sel,
    output logic [3:0]        an,
    output logic              busy,
    output logic              valid
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] op_a_reg, op_a_next;
    logic [DATA_W-1:0] op_b_reg, op_b_next;
    logic [1:0]        op_code_reg, op_code_next;
    logic [1:0]        digit_sel_reg, digit_sel_next;
    logic              settle_cnt_reg, settle_cnt_next;
    logic [RW-1:0]     refresh_cnt_reg, refresh_cnt_next;
    logic [FW-1:0]     frame_cnt_reg, frame_cnt_next;
    logic [3:0]        an_reg, an_next;
    logic              busy_reg, busy_next;
    logic              valid_reg, valid_next;
    logic [3:0]        an_run;
    logic              tick;

    assign tick = (refresh_cnt_reg == RW'(REFRESH_DIV - 1));

    always_comb begin
        state_next       = state_reg;
        op_a_next        = op_a_reg;
        op_b_next        = op_b_reg;
        op_code_next     = op_code_reg;
        digit_sel_next   = digit_sel_reg;
        settle_cnt_next  = settle_cnt_reg;
        refresh_cnt_next = refresh_cnt_reg;
        frame_cnt_next   = frame_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    op_a_next       = A;
                    op_b_next       = B;
                    settle_cnt_next = 1'b0;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg) begin
                    state_next       = RUN;
                    refresh_cnt_next = '0;
                    digit_sel_next   = 2'd0;
                    frame_cnt_next   = '0;
                    op_code_next     = 2'b00;
                end else begin
                    settle_cnt_next = 1'b1;
                end
            end
            RUN: begin
                // A recapture wins over any scan/frame event on the same edge
                if (load) begin
                    op_a_next       = A;
                    op_b_next       = B;
                    settle_cnt_next = 1'b0;
                    state_next      = SETTLE;
                end else begin
                    refresh_cnt_next = tick ? '0 : refresh_cnt_reg + RW'(1);
                    if (tick) begin
                        digit_sel_next = digit_sel_reg + 2'd1;
                        if (digit_sel_reg == 2'd3) begin
                            if (frame_cnt_reg == FW'(CYCLE_FRAMES - 1)) begin
                                frame_cnt_next = '0;
                                op_code_next   = (op_code_reg == 2'b00) ? 2'b01 : 2'b00;
                            end else begin
                                frame_cnt_next = frame_cnt_reg + FW'(1);
                            end
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One-hot-low anode pattern for the digit that will be shown after this edge
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_run[gi] = (digit_sel_next != 2'(gi));
        end
    endgenerate

    assign an_next    = (state_next == RUN) ? an_run : 4'b1111;
    assign busy_next  = (state_next == SETTLE);
    assign valid_next = (state_next == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            op_code_reg     <= 2'b00;
            digit_sel_reg   <= 2'd0;
            settle_cnt_reg  <= 1'b0;
            refresh_cnt_reg <= '0;
            frame_cnt_reg   <= '0;
            an_reg          <= 4'b1111;
            busy_reg        <= 1'b0;
            valid_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_a_reg        <= op_a_next;
            op_b_reg        <= op_b_next;
            op_code_reg     <= op_code_next;
            digit_sel_reg   <= digit_sel_next;
            settle_cnt_reg  <= settle_cnt_next;
            refresh_cnt_reg <= refresh_cnt_next;
            frame_cnt_reg   <= frame_cnt_next;
            an_reg          <= an_next;
            busy_reg        <= busy_next;
            valid_reg       <= valid_next;
        end
    end

    assign op_a      = op_a_reg;
    assign op_b      = op_b_reg;
    assign op_code   = op_code_reg;
    assign digit_sel = digit_sel_reg;
    assign an        = an_reg;
    assign busy      = busy_reg;
    assign valid     = valid_reg;

endmodule
